rob_occupancy_monitor: RTL and testbench

- Cycle-accurate shadow model of an N-wide ROB's head, tail and occupancy, with multi-slot branch checkpoint tracking.
- Each cycle it compares the model against the DUT's spots, tail and restore signals.
- It latches the first error, with code and cycle stamp, and counts error cycles.
- It sits beside the ROB in the core; it is instantiated by benches and, optionally, in FPGA debug builds.

---
 rtl/rob_mon_pkg.sv | 41 ++++
 rtl/rob_occupancy_monitor_if.sv | 52 +++++
 rtl/rob_ckpt_table.sv | 77 +++++++
 rtl/rob_occupancy_monitor.sv | 147 ++++++++++++++
 tb/tb_rob_occupancy_monitor.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/rob_mon_pkg.sv
// Shared types for the ROB occupancy monitor: error codes, FSM states,
// checkpoint slot layout and the expected-free-spots helper.
package rob_mon_pkg;

    // Slot fields are sized for the largest supported ROB and stamp width.
    localparam int CKPT_TAIL_W = 16;
    localparam int CKPT_SEQ_W  = 32;

    typedef enum logic [3:0] {
        ERR_NONE            = 4'd0,
        ERR_SPOTS           = 4'd1,
        ERR_OVERFLOW        = 4'd2,
        ERR_UNDERFLOW       = 4'd3,
        ERR_TAIL            = 4'd4,
        ERR_RESTORE         = 4'd5,
        ERR_CKPT            = 4'd6,
        ERR_DISP_IN_RESTORE = 4'd7
    } err_code_e;

    typedef enum logic [1:0] {
        ST_WAIT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_RECOVER = 2'd2,
        ST_ERROR   = 2'd3
    } state_e;

    typedef struct packed {
        logic                   valid;
        logic [CKPT_TAIL_W-1:0] tail;
        logic [CKPT_SEQ_W-1:0]  seq;
    } CKPT_ENTRY;

    function automatic int unsigned spots_expected(input int unsigned count,
                                                   input int unsigned n,
                                                   input int unsigned rob_sz);
        int unsigned free_slots;
        free_slots = (count >= rob_sz) ? 0 : rob_sz - count;
        return (free_slots < n) ? free_slots : n;
    endfunction

endpackage

// File: rtl/rob_occupancy_monitor_if.sv
// Signal bundle between a ROB (master side) and its occupancy monitor (slave side).
interface rob_occupancy_monitor_if #(
    parameter int N        = 4,
    parameter int ROB_SZ   = 32,
    parameter int NUM_CKPT = 4,
    parameter int CNT_W    = 16
);
    localparam int NSB = $clog2(N + 1);
    localparam int RB  = $clog2(ROB_SZ);
    localparam int CB  = $clog2(NUM_CKPT);
    localparam int PB  = (N > 1) ? $clog2(N) : 1;

    // No backpressure: every input is sampled each cycle, and restore_valid,
    // ckpt_take, ckpt_release and err_clear are single-cycle strobes.
    logic [NSB-1:0]   dispatch_num;
    logic [NSB-1:0]   retire_num;
    logic [NSB-1:0]   dut_spots;
    logic [RB-1:0]    dut_tail;
    logic             restore_valid;
    logic [CB-1:0]    restore_id;
    logic [RB-1:0]    restore_tail;
    logic             ckpt_take;
    logic [CB-1:0]    ckpt_id;
    logic [PB-1:0]    ckpt_pos;
    logic             ckpt_release;
    logic [CB-1:0]    release_id;
    logic             err_clear;
    logic             err_valid;
    logic [3:0]       err_code;
    logic [CNT_W-1:0] err_cycle;
    logic [CNT_W-1:0] err_count;
    logic [RB-1:0]    model_tail;
    logic [RB:0]      model_count;
    logic [1:0]       state;

    modport master (
        output dispatch_num, retire_num, dut_spots, dut_tail,
               restore_valid, restore_id, restore_tail,
               ckpt_take, ckpt_id, ckpt_pos, ckpt_release, release_id, err_clear,
        input  err_valid, err_code, err_cycle, err_count,
               model_tail, model_count, state
    );

    modport slave (
        input  dispatch_num, retire_num, dut_spots, dut_tail,
               restore_valid, restore_id, restore_tail,
               ckpt_take, ckpt_id, ckpt_pos, ckpt_release, release_id, err_clear,
        output err_valid, err_code, err_cycle, err_count,
               model_tail, model_count, state
    );

endinterface

// File: rtl/rob_ckpt_table.sv
// Branch checkpoint slots: take / release / restore-invalidate, plus the
// restore and checkpoint legality checks against the stored slots.
module rob_ckpt_table
    import rob_mon_pkg::*;
#(
    parameter int N        = 4,
    parameter int ROB_SZ   = 32,
    parameter int NUM_CKPT = 4,
    parameter int CNT_W    = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         take,
    input  logic [$clog2(NUM_CKPT)-1:0]  take_id,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0] take_pos,
    input  logic [$clog2(ROB_SZ)-1:0]    tail,
    input  logic                         rel_valid,
    input  logic [$clog2(NUM_CKPT)-1:0]  rel_id,
    input  logic                         restore_valid,
    input  logic [$clog2(NUM_CKPT)-1:0]  restore_id,
    input  logic [$clog2(ROB_SZ)-1:0]    restore_tail,
    output logic                         restore_err,
    output logic                         ckpt_err
);
    localparam int RB = $clog2(ROB_SZ);
    localparam int CB = $clog2(NUM_CKPT);

    CKPT_ENTRY             slots [NUM_CKPT];
    CKPT_ENTRY             rsv;
    logic [CNT_W-1:0]      seq_cnt;
    logic [NUM_CKPT-1:0]   younger;
    logic [RB-1:0]         take_tail;
    logic                  take_eff;

    assign rsv       = slots[restore_id];
    assign take_eff  = take && !restore_valid;
    assign take_tail = tail + RB'(take_pos) + RB'(1);

    assign restore_err = restore_valid &&
                         (!rsv.valid || rsv.tail != CKPT_TAIL_W'(restore_tail));

    assign ckpt_err = (take_eff && slots[take_id].valid &&
                       !(rel_valid && rel_id == take_id)) ||
                      (rel_valid && !slots[rel_id].valid);

    // A slot is younger than (or equal to) the restored one when the wrapped
    // sequence distance is non-negative.
    always_comb begin
        logic [CNT_W-1:0] age_diff;
        age_diff = '0;
        younger  = '0;
        for (int i = 0; i < NUM_CKPT; i++) begin
            age_diff   = CNT_W'(slots[i].seq - rsv.seq);
            younger[i] = ~age_diff[CNT_W-1];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CKPT; i++) slots[i] <= '0;
            seq_cnt <= '0;
        end else if (enable) begin
            for (int i = 0; i < NUM_CKPT; i++) begin
                if (rel_valid && rel_id == CB'(i)) slots[i].valid <= 1'b0;
                if (restore_valid && younger[i]) slots[i].valid <= 1'b0;
            end
            if (take_eff) begin
                slots[take_id] <= '{valid: 1'b1,
                                    tail:  CKPT_TAIL_W'(take_tail),
                                    seq:   CKPT_SEQ_W'(seq_cnt)};
                seq_cnt <= seq_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rob_occupancy_monitor.sv
// Shadow model of ROB head/tail/occupancy that checks the ROB every cycle and
// latches the first discrepancy with its code and cycle stamp.
module rob_occupancy_monitor
    import rob_mon_pkg::*;
#(
    parameter int N           = 4,
    parameter int ROB_SZ      = 32,
    parameter int NUM_CKPT    = 4,
    parameter int CNT_W       = 16,
    parameter int HALT_ON_ERR = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    rob_occupancy_monitor_if.slave  mon
);
    localparam int NSB = $clog2(N + 1);
    localparam int RB  = $clog2(ROB_SZ);

    logic [RB-1:0]    head, tail, head_next, tail_next;
    logic [RB:0]      count, count_next;
    logic [CNT_W-1:0] cycle_cnt, err_cycle_q, err_count_q;
    logic             err_valid_q;
    err_code_e        err_code_q, new_code;
    state_e           st;

    logic             chk_all, chk_spots, upd, any_err;
    logic             restore_err, ckpt_err;
    logic [7:1]       err_vec;
    logic [NSB-1:0]   spots_exp;
    logic [NSB:0]     avail;
    logic [RB+1:0]    cnt_add, cnt_ret;

    assign chk_all   = (st != ST_WAIT);
    assign chk_spots = chk_all && (st != ST_RECOVER);
    assign upd       = !(st == ST_ERROR && HALT_ON_ERR != 0);

    assign spots_exp = NSB'(spots_expected(32'(count), N, ROB_SZ));
    assign avail     = {1'b0, mon.dut_spots} + {1'b0, mon.retire_num};

    assign err_vec[1] = chk_spots && (mon.dut_spots != spots_exp);
    assign err_vec[2] = chk_all && ({1'b0, mon.dispatch_num} > avail);
    assign err_vec[3] = chk_all && ((RB+1)'(mon.retire_num) > count);
    assign err_vec[4] = chk_all && (mon.dut_tail != tail);
    assign err_vec[5] = chk_all && restore_err;
    assign err_vec[6] = chk_all && ckpt_err;
    assign err_vec[7] = chk_all && mon.restore_valid && (mon.dispatch_num != '0);
    assign any_err    = |err_vec;

    // Lowest-numbered code wins when several checks fire together.
    always_comb begin
        new_code = ERR_NONE;
        for (int i = 7; i >= 1; i--) begin
            if (err_vec[i]) new_code = err_code_e'(4'(i));
        end
    end

    // Retire first, then either a restore or a dispatch.
    always_comb begin
        head_next = head + RB'(mon.retire_num);
        cnt_add   = (RB+2)'(count) + (RB+2)'(mon.dispatch_num);
        cnt_ret   = (RB+2)'(mon.retire_num);
        if (mon.restore_valid) begin
            tail_next  = mon.restore_tail;
            count_next = {1'b0, mon.restore_tail - head_next};
        end else begin
            tail_next = tail + RB'(mon.dispatch_num);
            if (cnt_add < cnt_ret)
                count_next = '0;
            else if (cnt_add - cnt_ret > (RB+2)'(ROB_SZ))
                count_next = (RB+1)'(ROB_SZ);
            else
                count_next = (RB+1)'(cnt_add - cnt_ret);
        end
    end

    rob_ckpt_table #(
        .N        (N),
        .ROB_SZ   (ROB_SZ),
        .NUM_CKPT (NUM_CKPT),
        .CNT_W    (CNT_W)
    ) u_ckpt (
        .clock         (clock),
        .reset         (reset),
        .enable        (upd),
        .take          (mon.ckpt_take),
        .take_id       (mon.ckpt_id),
        .take_pos      (mon.ckpt_pos),
        .tail          (tail),
        .rel_valid     (mon.ckpt_release),
        .rel_id        (mon.release_id),
        .restore_valid (mon.restore_valid),
        .restore_id    (mon.restore_id),
        .restore_tail  (mon.restore_tail),
        .restore_err   (restore_err),
        .ckpt_err      (ckpt_err)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            cycle_cnt   <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            err_cycle_q <= '0;
            err_count_q <= '0;
            st          <= ST_WAIT;
        end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
            if (any_err && err_count_q != '1) err_count_q <= err_count_q + 1'b1;
            if (mon.err_clear) begin
                err_valid_q <= 1'b0;
                err_code_q  <= ERR_NONE;
            end
            if (any_err && (!err_valid_q || mon.err_clear)) begin
                err_valid_q <= 1'b1;
                err_code_q  <= new_code;
                err_cycle_q <= cycle_cnt;
            end
            if (upd) begin
                head  <= head_next;
                tail  <= tail_next;
                count <= count_next;
            end
            case (st)
                ST_WAIT: st <= ST_RUN;
                ST_RUN, ST_RECOVER: begin
                    if (any_err && HALT_ON_ERR != 0) st <= ST_ERROR;
                    else if (mon.restore_valid)      st <= ST_RECOVER;
                    else                             st <= ST_RUN;
                end
                ST_ERROR: if (mon.err_clear && !any_err) st <= ST_RUN;
                default: st <= ST_WAIT;
            endcase
        end
    end

    assign mon.err_valid   = err_valid_q;
    assign mon.err_code    = err_code_q;
    assign mon.err_cycle   = err_cycle_q;
    assign mon.err_count   = err_count_q;
    assign mon.model_tail  = tail;
    assign mon.model_count = count;
    assign mon.state       = st;

endmodule

// File: tb/tb_rob_occupancy_monitor.sv
// Directed bench for rob_occupancy_monitor (N=4, ROB_SZ=32, NUM_CKPT=4): each
// step queues hand-computed outputs; a negedge monitor pops and compares them.
module tb_rob_occupancy_monitor;

    typedef struct packed {
        logic        ev;
        logic [3:0]  code;
        logic [15:0] ecyc;
        logic [15:0] ecnt;
        logic [4:0]  tail;
        logic [5:0]  cnt;
        logic [1:0]  st;
    } exp_t;
    localparam int EXP_W = $bits(exp_t);

    logic clk;
    logic rst_n;

    logic [EXP_W-1:0] exp_q[$];
    int               id_q[$];
    int               rec_id = 0;
    int               checks = 0;
    int               errors = 0;

    rob_occupancy_monitor_if #(.N(4), .ROB_SZ(32), .NUM_CKPT(4), .CNT_W(16)) mon_if ();

    rob_occupancy_monitor #(
        .N(4), .ROB_SZ(32), .NUM_CKPT(4), .CNT_W(16), .HALT_ON_ERR(1)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .mon   (mon_if)
    );

    // Clock and reset
    initial begin
        clk   = 1'b0;
        rst_n = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_field(input string name, input int id,
                               input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (record %0d): got %0d, expected %0d", name, id, act, exp);
        end
    endtask

    // Monitor / scoreboard
    initial begin
        exp_t e;
        int   id;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                id = id_q.pop_front();
                check_field("err_valid",   id, 32'(mon_if.err_valid),   32'(e.ev));
                check_field("err_code",    id, 32'(mon_if.err_code),    32'(e.code));
                check_field("err_cycle",   id, 32'(mon_if.err_cycle),   32'(e.ecyc));
                check_field("err_count",   id, 32'(mon_if.err_count),   32'(e.ecnt));
                check_field("model_tail",  id, 32'(mon_if.model_tail),  32'(e.tail));
                check_field("model_count", id, 32'(mon_if.model_count), 32'(e.cnt));
                check_field("state",       id, 32'(mon_if.state),       32'(e.st));
            end
        end
    end

    task automatic push_exp(input int e_tail, input int e_cnt, input int e_st,
                            input int e_ev, input int e_code, input int e_ecyc,
                            input int e_ecnt);
        exp_t e;
        e.ev   = 1'(e_ev);
        e.code = 4'(e_code);
        e.ecyc = 16'(e_ecyc);
        e.ecnt = 16'(e_ecnt);
        e.tail = 5'(e_tail);
        e.cnt  = 6'(e_cnt);
        e.st   = 2'(e_st);
        exp_q.push_back(e);
        id_q.push_back(rec_id);
        rec_id++;
    endtask

    task automatic clear_inputs();
        mon_if.dispatch_num  = '0;
        mon_if.retire_num    = '0;
        mon_if.dut_spots     = '0;
        mon_if.dut_tail      = '0;
        mon_if.restore_valid = 1'b0;
        mon_if.restore_id    = '0;
        mon_if.restore_tail  = '0;
        mon_if.ckpt_take     = 1'b0;
        mon_if.ckpt_id       = '0;
        mon_if.ckpt_pos      = '0;
        mon_if.ckpt_release  = 1'b0;
        mon_if.release_id    = '0;
        mon_if.err_clear     = 1'b0;
    endtask

    // Asserts reset just after a clock edge; the check at the following negedge
    // happens before any further edge, so only an asynchronous reset satisfies it.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        clear_inputs();
        push_exp(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Driver: one clock cycle of stimulus plus the outputs expected after it.
    task automatic step(input int disp, input int ret, input int spots, input int dtail,
                        input int e_tail, input int e_cnt, input int e_st,
                        input int e_ev, input int e_code, input int e_ecyc,
                        input int e_ecnt);
        mon_if.dispatch_num = 3'(disp);
        mon_if.retire_num   = 3'(ret);
        mon_if.dut_spots    = 3'(spots);
        mon_if.dut_tail     = 5'(dtail);
        @(posedge clk);
        #1;
        push_exp(e_tail, e_cnt, e_st, e_ev, e_code, e_ecyc, e_ecnt);
        mon_if.restore_valid = 1'b0;
        mon_if.ckpt_take     = 1'b0;
        mon_if.ckpt_release  = 1'b0;
        mon_if.err_clear     = 1'b0;
        @(negedge clk);
    endtask

    // Stimulus
    initial begin
        clear_inputs();

        // Fill to full, then balanced traffic, then an overflow
        do_reset();
        step(0, 0, 4, 0,  0, 0, 1,  0, 0, 0, 0);
        for (int j = 1; j <= 8; j++)
            step(4, 0, 4, (4 * (j - 1)) % 32,  (4 * j) % 32, 4 * j, 1,  0, 0, 0, 0);
        step(0, 0, 0, 0,  0, 32, 1,  0, 0, 0, 0);
        step(2, 2, 0, 0,  2, 32, 1,  0, 0, 0, 0);
        step(3, 0, 0, 2,  5, 32, 3,  1, 2, 11, 1);
        mon_if.err_clear = 1'b1;
        step(0, 0, 0, 5,  5, 32, 1,  0, 0, 11, 1);

        // Checkpoints across the tail wrap, restore and younger-slot invalidation
        do_reset();
        step(0, 0, 4, 0,  0, 0, 1,  0, 0, 0, 0);
        for (int j = 1; j <= 7; j++)
            step(4, 0, 4, 4 * (j - 1),  4 * j, 4 * j, 1,  0, 0, 0, 0);
        step(2, 4, 4, 28,  30, 26, 1,  0, 0, 0, 0);
        mon_if.ckpt_take = 1'b1; mon_if.ckpt_id = 2'd1; mon_if.ckpt_pos = 2'd1;
        step(4, 0, 4, 30,  2, 30, 1,  0, 0, 0, 0);
        mon_if.ckpt_take = 1'b1; mon_if.ckpt_id = 2'd2; mon_if.ckpt_pos = 2'd0;
        step(1, 0, 2, 2,  3, 31, 1,  0, 0, 0, 0);
        mon_if.restore_valid = 1'b1; mon_if.restore_id = 2'd1; mon_if.restore_tail = 5'd0;
        step(0, 0, 1, 3,  0, 28, 2,  0, 0, 0, 0);
        step(0, 0, 0, 0,  0, 28, 1,  0, 0, 0, 0);
        mon_if.ckpt_release = 1'b1; mon_if.release_id = 2'd2;
        step(0, 0, 4, 0,  0, 28, 3,  1, 6, 13, 1);
        mon_if.err_clear = 1'b1;
        step(0, 0, 4, 0,  0, 28, 1,  0, 0, 13, 1);
        mon_if.ckpt_take = 1'b1; mon_if.ckpt_id = 2'd0; mon_if.ckpt_pos = 2'd0;
        step(1, 0, 4, 0,  1, 29, 1,  0, 0, 13, 1);
        mon_if.restore_valid = 1'b1; mon_if.restore_id = 2'd0; mon_if.restore_tail = 5'd2;
        step(0, 0, 3, 1,  2, 30, 3,  1, 5, 16, 2);
        step(1, 0, 2, 2,  2, 30, 3,  1, 5, 16, 2);
        mon_if.err_clear = 1'b1;
        step(0, 0, 2, 2,  2, 30, 1,  0, 0, 16, 2);
        step(2, 2, 2, 2,  4, 30, 1,  0, 0, 16, 2);
        step(2, 2, 2, 4,  6, 30, 1,  0, 0, 16, 2);

        // Reset mid-burst, masked first cycle, then error latching rules
        mon_if.dispatch_num = 3'd2; mon_if.retire_num = 3'd2;
        mon_if.dut_spots    = 3'd2; mon_if.dut_tail   = 5'd6;
        do_reset();
        mon_if.ckpt_release = 1'b1; mon_if.release_id = 2'd3;
        step(0, 0, 1, 7,  0, 0, 1,  0, 0, 0, 0);
        step(0, 0, 3, 1,  0, 0, 3,  1, 1, 1, 1);
        step(0, 0, 3, 0,  0, 0, 3,  1, 1, 1, 2);
        mon_if.err_clear = 1'b1;
        step(0, 0, 4, 2,  0, 0, 3,  1, 4, 3, 3);
        mon_if.err_clear = 1'b1;
        step(0, 0, 4, 0,  0, 0, 1,  0, 0, 3, 3);
        step(0, 1, 4, 0,  0, 0, 3,  1, 3, 5, 4);
        mon_if.err_clear = 1'b1;
        step(0, 0, 4, 0,  0, 0, 1,  0, 0, 5, 4);
        mon_if.ckpt_take = 1'b1; mon_if.ckpt_id = 2'd3; mon_if.ckpt_pos = 2'd0;
        step(1, 0, 4, 0,  1, 1, 1,  0, 0, 5, 4);
        mon_if.restore_valid = 1'b1; mon_if.restore_id = 2'd3; mon_if.restore_tail = 5'd1;
        step(2, 0, 4, 1,  1, 0, 3,  1, 7, 8, 5);

        // Final report
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending records, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout at %0t, expected completion", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
